// File: rtl/mesm6_alu_seq.sv
// MESM-6 style sequential ALU: logical, end-around-carry add, popcount, CLZ,
// two-word shift and iterative shift-add multiply behind a start/done handshake.
module mesm6_alu_seq #(
  parameter int unsigned WIDTH    = 48,
  parameter int unsigned MUL_STEP = 1,
  parameter int unsigned SHW      = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned NSteps = WIDTH / MUL_STEP;
  localparam int unsigned CntW   = $clog2(NSteps + 1);
  localparam int unsigned PW     = WIDTH + MUL_STEP;

  localparam logic [3:0] OpNop   = 4'd0;
  localparam logic [3:0] OpAnd   = 4'd1;
  localparam logic [3:0] OpOr    = 4'd2;
  localparam logic [3:0] OpXor   = 4'd3;
  localparam logic [3:0] OpAddc  = 4'd4;
  localparam logic [3:0] OpCount = 4'd5;
  localparam logic [3:0] OpClz   = 4'd6;
  localparam logic [3:0] OpShift = 4'd7;
  localparam logic [3:0] OpMul   = 4'd8;

  typedef enum logic [2:0] {StIdle, StExec, StFix, StMul, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d, y_q, y_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;

  function automatic logic [WIDTH-1:0] popcnt(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + WIDTH'(v[i]);
    return c;
  endfunction

  // Leading zeros plus one; zero operand yields zero.
  function automatic logic [WIDTH-1:0] clz_plus1(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] z;
    logic             found;
    z     = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      z = z + WIDTH'(1);
      end
    end
    return found ? z + WIDTH'(1) : '0;
  endfunction

  logic [WIDTH-1:0]   clz_z, add_lhs;
  logic [WIDTH:0]     add_sum;
  logic [SHW-1:0]     sh_n;
  logic [2*WIDTH-1:0] sh_right, sh_left;
  logic [MUL_STEP-1:0] mul_digit;
  logic [PW-1:0]      mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  always_comb begin
    clz_z = clz_plus1(a_q);
    case (op_q)
      OpCount: add_lhs = popcnt(a_q);
      OpClz:   add_lhs = clz_z;
      default: add_lhs = a_q;
    endcase
    add_sum  = {1'b0, add_lhs} + {1'b0, b_q};
    sh_n     = b_q[WIDTH-2 -: SHW];
    sh_right = {a_q, {WIDTH{1'b0}}} >> sh_n;
    sh_left  = {{WIDTH{1'b0}}, a_q} << sh_n;
    // Retire MUL_STEP multiplier bits: add partial product, shift {hi,lo} right.
    mul_digit = acc_lo_q[MUL_STEP-1:0];
    mul_sum   = PW'(acc_hi_q) + PW'(a_q) * PW'(mul_digit);
    mul_next  = (2*WIDTH)'({mul_sum, acc_lo_q} >> MUL_STEP);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    carry_d  = carry_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    y_d      = y_q;
    err_d    = err_q;
    done_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start && (op != OpNop)) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          err_d   = 1'b0;
          state_d = StExec;
        end
      end
      StExec: begin
        case (op_q)
          OpAnd: begin
            result_d = a_q & b_q;
            y_d      = '0;
            done_d   = 1'b1;
            state_d  = StDone;
          end
          OpOr: begin
            result_d = a_q | b_q;
            y_d      = '0;
            done_d   = 1'b1;
            state_d  = StDone;
          end
          OpXor: begin
            result_d = a_q ^ b_q;
            y_d      = a_q;
            done_d   = 1'b1;
            state_d  = StDone;
          end
          OpAddc, OpCount, OpClz: begin
            result_d = add_sum[WIDTH-1:0];
            carry_d  = add_sum[WIDTH];
            y_d      = (op_q == OpClz) ? (a_q << clz_z) : '0;
            state_d  = StFix;
          end
          OpShift: begin
            if (b_q[WIDTH-1]) begin
              result_d = sh_right[2*WIDTH-1:WIDTH];
              y_d      = sh_right[WIDTH-1:0];
            end else begin
              result_d = sh_left[WIDTH-1:0];
              y_d      = sh_left[2*WIDTH-1:WIDTH];
            end
            done_d  = 1'b1;
            state_d = StDone;
          end
          OpMul: begin
            acc_hi_d = '0;
            acc_lo_d = b_q;
            cnt_d    = CntW'(NSteps);
            state_d  = StMul;
          end
          default: begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = StDone;
          end
        endcase
      end
      StFix: begin
        result_d = result_q + WIDTH'(carry_q);
        done_d   = 1'b1;
        state_d  = StDone;
      end
      StMul: begin
        acc_hi_d = mul_next[2*WIDTH-1:WIDTH];
        acc_lo_d = mul_next[WIDTH-1:0];
        cnt_d    = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          result_d = mul_next[2*WIDTH-1:WIDTH];
          y_d      = mul_next[WIDTH-1:0];
          done_d   = 1'b1;
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      y_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      y_q      <= y_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign result = result_q;
  assign y      = y_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mesm6_alu_seq.sv
// Directed and random checks of mesm6_alu_seq against a behavioural model.
module tb_mesm6_alu_seq;

  localparam int unsigned W   = 48;
  localparam int unsigned MS  = 1;
  localparam int unsigned SHW = $clog2(W) + 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] result, y;
  logic         busy, done, err;

  always #5 clk = ~clk;

  mesm6_alu_seq #(.WIDTH(W), .MUL_STEP(MS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .result  (result),
    .y       (y),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  int n_checks = 0;
  int n_err = 0;
  logic [W-1:0] prev_r = '0, prev_y = '0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    return W'({$urandom(), $urandom()});
  endfunction

  function automatic logic [W-1:0] mk_sh(input logic dir, input int n);
    return {dir, SHW'(n), {(W-1-SHW){1'b0}}};
  endfunction

  // Behavioural reference: expected result/y/err and start-to-done latency.
  function automatic void model(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                                output logic [W-1:0] r, output logic [W-1:0] yv,
                                output logic e, output int lat);
    logic [W:0]     s;
    logic [W-1:0]   lhs, t;
    logic [2*W-1:0] p;
    int bl, z, n;
    r = prev_r; yv = prev_y; e = 1'b0; lat = 2;
    case (o)
      4'd1: begin r = av & bv; yv = '0; end
      4'd2: begin r = av | bv; yv = '0; end
      4'd3: begin r = av ^ bv; yv = av; end
      4'd4, 4'd5, 4'd6: begin
        t = av; bl = 0;
        while (t != 0) begin t = t >> 1; bl++; end
        z = (av == 0) ? 0 : W - bl + 1;
        if (o == 4'd4)      lhs = av;
        else if (o == 4'd5) lhs = W'($countones(av));
        else                lhs = W'(z);
        s = {1'b0, lhs} + {1'b0, bv};
        r = s[W-1:0] + W'(s[W]);
        yv = (o == 4'd6) ? (av << z) : '0;
        lat = 3;
      end
      4'd7: begin
        n = int'(bv[W-2 -: SHW]);
        r = '0; yv = '0;
        for (int i = 0; i < W; i++) begin
          if (bv[W-1]) begin
            if (i + n < W)          r[i]  = av[i+n];
            else if (i + n < 2 * W) yv[i] = av[i+n-W];
          end else begin
            if (i - n >= 0)                    r[i]  = av[i-n];
            if (i + W - n >= 0 && i + W - n < W) yv[i] = av[i+W-n];
          end
        end
      end
      4'd8: begin
        p = (2*W)'(av) * (2*W)'(bv);
        r = p[2*W-1:W]; yv = p[W-1:0];
        lat = 2 + W / MS;
      end
      default: e = 1'b1;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op_v,
                        input logic [W-1:0] a_v, input logic [W-1:0] b_v);
    logic [W-1:0] er, ey;
    logic ee, busy_ok;
    int el, j;
    model(op_v, a_v, b_v, er, ey, ee, el);
    @(negedge clk);
    start = 1'b1; op = op_v; a = a_v; b = b_v;
    @(posedge clk);
    #1;
    start = 1'b0; op = 4'($urandom()); a = rnd(); b = rnd();
    chk({tag, "_err_clr"}, W'(err), W'(0));
    busy_ok = 1'b1;
    for (j = 0; j < 200; j++) begin
      @(negedge clk);
      if (done === 1'b1) break;
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
    end
    chk({tag, "_lat"}, W'(j + 1), W'(el));
    chk({tag, "_busy"}, W'(busy_ok && busy === 1'b1), W'(1));
    chk({tag, "_res"}, result, er);
    chk({tag, "_y"}, y, ey);
    chk({tag, "_errf"}, W'(err), W'(ee));
    @(posedge clk);
    #1;
    chk({tag, "_done_fall"}, W'({busy, done}), W'(0));
    prev_r = er; prev_y = ey;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] er, ey, ma, mb;
    logic ee;
    int el, dcount;

    #3;
    chk("rst_result", result, '0);
    chk("rst_y", y, '0);
    chk("rst_flags", W'({busy, done, err}), W'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_op("addc_wrap", 4'd4, 48'hFFFF_FFFF_FFFF, 48'h1);
    chk("addc_const", result, 48'h1);
    run_op("clz", 4'd6, 48'h0000_8000_0000, 48'd5);
    chk("clz_const", result, 48'd22);
    run_op("count", 4'd5, 48'hF0F0, 48'd0);
    chk("count_const", result, 48'd8);
    run_op("shr4", 4'd7, 48'h8000_0000_0000, mk_sh(1'b1, 4));
    chk("shr4_const", result, 48'h0800_0000_0000);
    run_op("shl1", 4'd7, 48'h8000_0000_0001, mk_sh(1'b0, 1));
    chk("shl1_const", {result[23:0], y[23:0]}, {24'd2, 24'd1});
    run_op("sh96", 4'd7, 48'hDEAD_BEEF_1234, mk_sh(1'b1, 96));
    run_op("shr0", 4'd7, 48'h1234_5678_9ABC, mk_sh(1'b1, 0));
    run_op("shl0", 4'd7, 48'hCAFE_0000_F00D, mk_sh(1'b0, 0));
    run_op("and", 4'd1, 48'hFF00_FF00_FF00, 48'h0F0F_0F0F_0F0F);
    run_op("or", 4'd2, 48'hFF00_0000_0001, 48'h00FF_0000_0002);
    run_op("xor", 4'd3, 48'hAAAA_5555_AAAA, 48'hFFFF_0000_FFFF);
    run_op("mul2", 4'd8, 48'hFFFF_FFFF_FFFF, 48'd2);
    chk("mul2_const", y, 48'hFFFF_FFFF_FFFE);
    run_op("mul0", 4'd8, 48'h1234_5678_9ABC, 48'd0);
    run_op("xor_pre", 4'd3, 48'h1111_2222_3333, 48'h4444_5555_6666);

    // Idle with start low, then a NOP start: nothing moves.
    repeat (4) begin
      @(negedge clk);
      a = rnd(); b = rnd(); op = 4'($urandom());
    end
    chk("idle_res", result, prev_r);
    chk("idle_y", y, prev_y);
    @(negedge clk);
    start = 1'b1; op = 4'd0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("nop_flags", W'({busy, done}), W'(0));
    chk("nop_res", result, prev_r);

    run_op("illegal", 4'hF, rnd(), rnd());
    run_op("after_ill", 4'd1, rnd(), rnd());

    // start with op=1 while a MUL is running must be ignored.
    ma = 48'h1234_5678_9ABC; mb = 48'hFEDC_BA98_7654;
    model(4'd8, ma, mb, er, ey, ee, el);
    @(negedge clk);
    start = 1'b1; op = 4'd8; a = ma; b = mb;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; op = 4'd1; a = rnd(); b = rnd();
    @(negedge clk);
    start = 1'b0;
    dcount = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dcount++;
        if (dcount == 1) begin
          chk("intr_res", result, er);
          chk("intr_y", y, ey);
        end
      end
    end
    chk("intr_done_cnt", W'(dcount), W'(1));
    prev_r = er; prev_y = ey;

    // Asynchronous reset in the middle of a MUL.
    @(negedge clk);
    start = 1'b1; op = 4'd8; a = rnd(); b = rnd();
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mrst_res", result, '0);
    chk("mrst_y", y, '0);
    chk("mrst_flags", W'({busy, done, err}), W'(0));
    @(negedge clk);
    reset_n = 1'b1;
    prev_r = '0; prev_y = '0;
    run_op("post_rst_mul", 4'd8, rnd(), rnd());

    for (int k = 0; k < 30; k++) begin
      logic [3:0] rop;
      rop = 4'($urandom_range(1, 9));
      if (rop == 4'd9) rop = 4'($urandom_range(9, 15));
      run_op("rand", rop, rnd(), rnd());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mesm6_alu_seq.md
# mesm6_alu_seq

Parametrised, handshaked successor to the MESM-6 integer ALU. It executes the logical, end-around-carry add, population-count, leading-zero, two-word shift and new iterative unsigned multiply operations on WIDTH-bit operands. Operations start on an explicit start pulse and signal completion with a one-cycle done pulse. The block sits between the accumulator/Y register file and the control unit.

## Interface
- WIDTH, 48: operand width. Must be ≥ 8.
- MUL_STEP, 1: multiplier bits retired per MUL cycle. Must divide WIDTH and be in 1..8.
- SHW, $clog2(WIDTH)+1: width of the shift-amount field.
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- op  in  4  operation code; sampled with start.
- a, b  in  WIDTH  operands; sampled with start and held internally.
- result  out  WIDTH  main result, registered.
- y  out  WIDTH  low/auxiliary word, registered.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  high with done when op is illegal; otherwise low.

## Operation
- Op codes:
  - 0 NOP: start ignored.
  - 1 AND: result=a&b, y=0.
  - 2 OR: result=a|b, y=0.
  - 3 XOR: result=a^b, y=a.
  - 4 ADDC: {c,s}=a+b, then result=s+c (end-around carry), y=0.
  - 5 COUNT: as ADDC with popcount(a) in place of a.
  - 6 CLZ: as ADDC with z in place of a, where z = leading zeros+1 (z=0 when a==0); y=a<<z, truncated to WIDTH.
  - 7 SHIFT: n=b[WIDTH-2 -: SHW].
    - b[WIDTH-1]=1 (right): {result,y} = {a, WIDTH'b0} >> n.
    - b[WIDTH-1]=0 (left): {y,result} = {WIDTH'b0, a} << n.
    - n ≥ 2·WIDTH gives all zeros.
  - 8 MUL: unsigned a×b, 2·WIDTH bits; result=high word, y=low word. Shift-add, MUL_STEP multiplier bits per cycle.
  - 9–15: illegal.
- FSM states: IDLE, EXEC, FIX, MUL, DONE.
  - IDLE & start & op≠0 → operands latched; go to EXEC.
  - EXEC, op 1/2/3/7: outputs written → DONE.
  - EXEC, op 4/5/6: sum and carry latched → FIX.
  - EXEC, op 8: accumulator cleared, iteration counter = WIDTH/MUL_STEP → MUL.
  - EXEC, op 9–15: result and y unchanged, err=1 → DONE.
  - FIX: result=result+carry (WIDTH-bit wrap) → DONE.
  - MUL: one step per cycle, counter decrements; last step writes result/y → DONE.
  - DONE: done=1 for exactly this cycle → IDLE.
- start outside IDLE is ignored; no queueing. A new start is accepted in the cycle after DONE.
- a, b and op may change freely after being accepted.
- result and y hold their value until the next operation writes them.
- err clears at the next accepted start.
- Reset (asynchronous, any state, including mid-MUL) forces IDLE and zeroes all outputs: result, y, busy, done, err = 0.

## Timing
- Start accepted at edge k. Edges at which done is high and outputs are valid:
  - Logical, SHIFT and illegal ops: k+2.
  - ADDC/COUNT/CLZ: k+3.
  - MUL: k+2+WIDTH/MUL_STEP.
- busy rises at edge k and falls at the edge where done falls.
- Minimum start-to-start spacing = latency+1.
- Boundaries:
  - FIX carry wraps within WIDTH: an all-ones sum plus carry gives 0.
  - SHIFT n=0 passes a through: right → result=a, y=0; left → result=a, y=0.
  - MUL by 0 gives result=y=0 at full latency; there is no early exit.
  - start low in IDLE: outputs hold.

## Test plan
- ADDC, a=0xFFFF_FFFF_FFFF, b=1 (WIDTH=48) → result=0x0000_0000_0001, y=0; done exactly at k+3; busy high k..k+3.
- CLZ, a=0x0000_8000_0000, b=5 → result=22 (z=17), y=0. COUNT, a=0xF0F0, b=0 → result=8.
- SHIFT right, a=0x8000_0000_0000, b={1,n=4,...} → result=0x0800_0000_0000, y=0. SHIFT left, a=0x8000_0000_0001, n=1 → result=2, y=1. SHIFT n=96 → result=y=0.
- MUL, a=0xFFFF_FFFF_FFFF, b=2 → result=1, y=0xFFFF_FFFF_FFFE.
  - MUL_STEP=1: done at k+50.
  - MUL_STEP=4: done at k+14.
  - Random a,b checked against a 96-bit reference product.
- start pulsed during busy MUL with op=1 → ignored; MUL result intact; a single done.
- Illegal op=0xF → done with err=1 at k+2, prior result/y unchanged. reset_n low mid-MUL → all outputs 0 immediately; the next start runs cleanly.
